// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, FSM states and frame helpers
package uart_pkg;
  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;
  function automatic logic [3:0] len_bits(input logic [1:0] len);
    return 4'd5 + {2'b00, len};
  endfunction
  function automatic logic parity(input logic [7:0] d, input logic [1:0] len, input logic odd);
    logic [7:0] m;
    m = 8'hFF >> (4'd8 - len_bits(len));
    return (^(d & m)) ^ odd;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchroniser for the asynchronous rx line, idles high
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs
);
  logic [STAGES-1:0] ff;
  // shift rx through the chain; reset to the idle (high) level
  always_ff @(posedge clk) ff <= !rst ? '1 : {ff[STAGES-2:0], rx};
  assign rxs = ff[STAGES-1];
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive deframer; define UART_RX_MAJORITY_VOTE_EN for 2-of-3 bit voting
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] cfg_len,
  input  logic       cfg_par_en,
  input  logic       cfg_par_odd,
  input  logic       cfg_stop2,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  state_t        state;
  logic          rxs, bit_v, samp, perr;
  logic [TW-1:0] tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    shr;
  logic [1:0]    c_len;
  logic          c_par_en, c_par_odd, c_stop2;
  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .rx(rx), .rxs(rxs));
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist;
  // keep the two previous tick samples so the vote spans three consecutive ticks
  always_ff @(posedge clk) hist <= !rst ? 2'b11 : baud_tick ? {hist[0], rxs} : hist;
  assign bit_v = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign bit_v = rxs;
`endif
  assign samp = baud_tick && tcnt == (state == START ? HALF : FULL);
  assign busy = state != IDLE;
  // frame FSM: every transition and counter step is qualified by baud_tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      shr        <= '0;
      perr       <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      c_len      <= LEN_8;
      c_par_en   <= 1'b0;
      c_par_odd  <= 1'b0;
      c_stop2    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (baud_tick) begin
        tcnt <= (state == IDLE || samp) ? '0 : tcnt + TW'(1);
        case (state)
          IDLE: if (!rxs) begin
            state     <= START;
            c_len     <= cfg_len;
            c_par_en  <= cfg_par_en;
            c_par_odd <= cfg_par_odd;
            c_stop2   <= cfg_stop2;
          end
          START: if (samp) begin
            state <= bit_v ? IDLE : DATA;
            bcnt  <= '0;
            shr   <= '0;
            perr  <= 1'b0;
          end
          DATA: if (samp) begin
            shr[bcnt] <= bit_v;
            bcnt      <= bcnt + 3'd1;
            if (bcnt == 3'(len_bits(c_len) - 4'd1)) state <= c_par_en ? PARITY : STOP1;
          end
          PARITY: if (samp) begin
            perr  <= bit_v != parity(shr, c_len, c_par_odd);
            state <= STOP1;
          end
          STOP1, STOP2: if (samp) begin
            if (state == STOP1 && c_stop2 && bit_v && !perr) state <= STOP2;
            else begin
              data       <= shr;
              parity_err <= perr;
              frame_err  <= !bit_v;
              data_valid <= 1'b1;
              state      <= bit_v ? IDLE : BREAK;
            end
          end
          BREAK: if (rxs) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: table-driven and scoreboard checks of the UART receive deframer
module tb_uart_rx_deframer;
  import uart_pkg::*;
  localparam int OS = 16;
  typedef struct {logic [7:0] d; logic p; logic f;} exp_t;
  typedef struct {
    logic [1:0] len; logic pe; logic po; logic st2;
    logic [7:0] d; int nb; int pb; logic s1; logic s2;
    logic [7:0] ed; logic ep; logic ef;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b0, baud_tick = 1'b0, rx = 1'b1;
  logic [1:0] cfg_len = LEN_8;
  logic       cfg_par_en = 1'b1, cfg_par_odd = 1'b0, cfg_stop2 = 1'b0;
  logic [7:0] data;
  logic       data_valid, parity_err, frame_err, busy;
  int         n_cmp = 0, n_err = 0, dv_cnt = 0, div = 2;
  exp_t       q[$];
  vec_t       v[11];

  uart_rx_deframer #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .cfg_len(cfg_len), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .data(data), .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // scoreboard: every data_valid pulse pops one expected frame
  always @(posedge clk) begin
    #1;
    if (data_valid) begin
      exp_t e;
      dv_cnt++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_dv: got data %0h with empty scoreboard", data);
      end else begin
        e = q.pop_front();
        check("dv_data", int'(data), int'(e.d));
        check("dv_parity_err", int'(parity_err), int'(e.p));
        check("dv_frame_err", int'(frame_err), int'(e.f));
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
      repeat (div - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    ticks(n);
  endtask

  task automatic frame(input logic [7:0] d, input int nb, input int pb, input logic s1, input logic s2,
                       input logic two, output logic [11:0] lv, output int n);
    lv = '1;
    n = 0;
    lv[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin lv[n] = d[i]; n++; end
    if (pb >= 0) begin lv[n] = pb[0]; n++; end
    lv[n] = s1; n++;
    if (two) begin lv[n] = s2; n++; end
  endtask

  task automatic play(input logic [11:0] lv, input int lo, input int hi, input int glitch);
    for (int b = lo; b < hi; b++)
      for (int t = 0; t < OS; t++) begin
        rx = (b == glitch && t == 8) ? !lv[b] : lv[b];
        ticks(1);
      end
  endtask

  initial begin
    logic [11:0] lv;
    int n, dv0;
    v[0]  = '{LEN_8, 1'b1, 1'b0, 1'b0, 8'h3A, 8,  0, 1'b1, 1'b1, 8'h3A, 1'b0, 1'b0};
    v[1]  = '{LEN_6, 1'b1, 1'b0, 1'b0, 8'h3A, 6,  0, 1'b1, 1'b1, 8'h3A, 1'b0, 1'b0};
    v[2]  = '{LEN_6, 1'b0, 1'b0, 1'b0, 8'hBE, 8, -1, 1'b1, 1'b1, 8'h3E, 1'b0, 1'b1};
    v[3]  = '{LEN_8, 1'b1, 1'b1, 1'b0, 8'h3A, 8,  0, 1'b1, 1'b1, 8'h3A, 1'b1, 1'b0};
    v[4]  = '{LEN_8, 1'b1, 1'b1, 1'b0, 8'h3A, 8,  1, 1'b1, 1'b1, 8'h3A, 1'b0, 1'b0};
    v[5]  = '{LEN_8, 1'b1, 1'b0, 1'b1, 8'h3A, 8,  0, 1'b1, 1'b0, 8'h3A, 1'b0, 1'b1};
    v[6]  = '{LEN_8, 1'b1, 1'b0, 1'b1, 8'h3A, 8,  0, 1'b1, 1'b1, 8'h3A, 1'b0, 1'b0};
    v[7]  = '{LEN_5, 1'b0, 1'b0, 1'b0, 8'h15, 5, -1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0};
    v[8]  = '{LEN_7, 1'b1, 1'b1, 1'b0, 8'h5A, 7,  1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    v[9]  = '{LEN_8, 1'b0, 1'b0, 1'b0, 8'hA5, 8, -1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
    v[10] = '{LEN_8, 1'b1, 1'b0, 1'b1, 8'h3A, 8,  1, 1'b1, 1'b1, 8'h3A, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_data", int'(data), 0);
    check("rst_dv", int'(data_valid), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    idle(4);
    for (int i = 0; i < 11; i++) begin
      cfg_len = v[i].len; cfg_par_en = v[i].pe; cfg_par_odd = v[i].po; cfg_stop2 = v[i].st2;
      q.push_back('{v[i].ed, v[i].ep, v[i].ef});
      frame(v[i].d, v[i].nb, v[i].pb, v[i].s1, v[i].s2, v[i].st2, lv, n);
      play(lv, 0, n, -1);
      idle(2 * OS);
      check($sformatf("row%0d_drained", i), q.size(), 0);
      check($sformatf("row%0d_busy", i), int'(busy), 0);
    end
    dv0 = dv_cnt;
    rx = 1'b0;
    ticks(4);
    idle(2 * OS);
    check("glitch_no_dv", dv_cnt - dv0, 0);
    check("glitch_busy", int'(busy), 0);
    cfg_len = LEN_8; cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b1;
    dv0 = dv_cnt;
    q.push_back('{8'h3A, 1'b0, 1'b1});
    frame(8'h3A, 8, 0, 1'b1, 1'b0, 1'b1, lv, n);
    play(lv, 0, n, -1);
    rx = 1'b0;
    ticks(3 * OS);
    check("break_one_dv", dv_cnt - dv0, 1);
    check("break_busy", int'(busy), 1);
    idle(OS);
    check("break_released", int'(busy), 0);
    q.push_back('{8'h3A, 1'b0, 1'b0});
    frame(8'h3A, 8, 0, 1'b1, 1'b1, 1'b1, lv, n);
    play(lv, 0, n, -1);
    idle(2 * OS);
    check("break_next_frame", dv_cnt - dv0, 2);
    cfg_stop2 = 1'b0;
    q.push_back('{8'h3A, 1'b0, 1'b0});
    frame(8'h3A, 8, 0, 1'b1, 1'b1, 1'b0, lv, n);
    play(lv, 0, 4, -1);
    cfg_len = LEN_5; cfg_par_en = 1'b0; cfg_par_odd = 1'b1; cfg_stop2 = 1'b1;
    play(lv, 4, n, -1);
    idle(2 * OS);
    check("cfg_mid_drained", q.size(), 0);
    cfg_len = LEN_8; cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    dv0 = dv_cnt;
    frame(8'h3A, 8, 0, 1'b1, 1'b1, 1'b0, lv, n);
    play(lv, 0, 5, -1);
    rst = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_data", int'(data), 0);
    check("rstmid_flags", int'({parity_err, frame_err, data_valid}), 0);
    check("rstmid_busy", int'(busy), 0);
    rst = 1'b1;
    idle(3 * OS);
    check("rstmid_no_dv", dv_cnt - dv0, 0);
    check("rstmid_idle", int'(busy), 0);
    foreach (v[k]) if (k < 2) begin
      div = (k == 0) ? 2 : 4;
      dv0 = dv_cnt;
      q.push_back('{8'h55, 1'b0, 1'b0});
      q.push_back('{8'h55, 1'b0, 1'b0});
      frame(8'h55, 8, 0, 1'b1, 1'b1, 1'b0, lv, n);
      play(lv, 0, n, -1);
      play(lv, 0, n, -1);
      idle(2 * OS);
      check($sformatf("b2b_div%0d_count", div), dv_cnt - dv0, 2);
      check($sformatf("b2b_div%0d_drained", div), q.size(), 0);
    end
    div = 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    q.push_back('{8'h3A, 1'b0, 1'b0});
    frame(8'h3A, 8, 0, 1'b1, 1'b1, 1'b0, lv, n);
    play(lv, 0, 4, 3);
    play(lv, 4, n, 6);
    idle(2 * OS);
    check("vote_drained", q.size(), 0);
`endif
    check("end_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial receive front end of the UART.
- Synchronises the asynchronous Rx line, detects and validates the start bit, and oversamples each bit at mid-period.
- Assembles 5–8 data bits LSB-first, checks optional parity and 1 or 2 stop bits.
- Presents one byte per frame, with error flags, to the downstream command decoder / config-register stage.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, ≥8).
- SYNC_STAGES, 2, flip-flops in the rx synchroniser (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- baud_tick  in  1  one-clk enable pulse at OVERSAMPLE × baud rate, from the baud generator
- rx  in  1  asynchronous serial input; idles high
- cfg_len  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- cfg_par_en  in  1  parity bit present
- cfg_par_odd  in  1  1=odd parity, 0=even parity
- cfg_stop2  in  1  1=two stop bits, 0=one stop bit
- data  out  8  received word; bits above the configured length are 0
- data_valid  out  1  one-clk pulse, frame complete
- parity_err  out  1  parity mismatch for the frame flagged by data_valid
- frame_err  out  1  a stop bit sampled low for that frame
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst low at a clk edge):
  - state=IDLE; data=0; data_valid=0; parity_err=0; frame_err=0; busy=0.
  - Synchroniser flops=1; tick counter=0; bit counter=0.
- rx passes through SYNC_STAGES flops; all logic uses the synchronised rxs only.
- All counters advance only on clks with baud_tick=1.
- Config latch:
  - cfg_* is latched into shadow registers on the clk that leaves IDLE.
  - A config change mid-frame has no effect until the next frame.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- IDLE: when rxs=0 on a baud_tick → START, tick counter cleared.
- START: at tick OVERSAMPLE/2−1, sample rxs.
  - rxs=1 → false start; back to IDLE, no output.
  - rxs=0 → DATA; tick counter cleared; bit counter=0.
- Sampling: from START onward, each bit is sampled once every OVERSAMPLE ticks, i.e. at mid-bit.
- DATA:
  - Sampled bit is shifted into data position bitcnt, LSB-first.
  - After bit len−1: → PARITY if par_en, else → STOP1.
- PARITY:
  - Expected parity = XOR of the received data bits, inverted when odd.
  - Mismatch sets the internal perr flag.
- STOP1: sample.
  - Low → ferr set.
  - If stop2 and no error so far → STOP2; else frame complete.
- STOP2: sample; low → ferr set; frame complete.
- Frame complete:
  - On the clk after the final stop sample: data_valid=1 for exactly one clk.
  - data, parity_err and frame_err update on that same clk and hold until the next data_valid.
  - An errored frame still pulses data_valid, with its flags set.
  - State → IDLE, or → BREAK if the final stop sample was 0.
- BREAK: wait until rxs=1, then → IDLE. This prevents a held-low line retriggering START.
- Back-to-back frames:
  - Returning to IDLE at mid-stop-bit lets the next start edge be detected with no lost frame.
  - A start edge up to OVERSAMPLE/2 ticks early is tolerated.
- baud_tick removed mid-frame: state freezes; no timeout.
- Reset mid-frame: frame is discarded; no data_valid.

Optional Feature:
- UART_RX_MAJORITY_VOTE_EN defined:
  - Each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at ticks OVERSAMPLE/2−2, −1 and 0 relative to mid-bit.
  - Implemented as a 3-bit shift of rxs taken on baud_tick.
- Undefined: single sample at OVERSAMPLE/2−1.
- Latency of data_valid is identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - cfg_len encodings (LEN_5..LEN_8)
  - state enum
  - function len_bits(cfg_len) returning 5..8
  - function parity(data, len, odd)
- The command decoder reuses the same package.
- One natural sub-module: uart_rx_sync (SYNC_STAGES synchroniser). The majority voter stays inline.

Test Plan:
- Default config (len=11, par_en=1, even, stop2=0), 0x3A sent at 16 ticks/bit → one data_valid; data=0x3A; parity_err=0; frame_err=0; busy low after the pulse.
- len=01 (6 bits), 6'b111010 with even parity → data=0x3A, upper bits 0. Then send 8'b10111110 → data contains only the low 6 bits.
- par_en=1, odd, 0x3A sent with even parity bit (0) → parity_err=1, frame_err=0, data=0x3A. Resend with parity 1 → both flags 0.
- stop2=1, 0x3A with the second stop bit driven low → frame_err=1. Then rx held low 3 bit-times → no extra data_valid until rx returns high and a new start bit arrives.
- Glitch: rx low for 4 ticks → no data_valid, busy returns to 0. Also: cfg changed mid-frame and rst asserted mid-frame → frame parsed with the old config; after reset no output and all outputs 0.
- Two 0x55 frames back-to-back (next start immediately after the stop bit), at the 9600 and 4800 tick rates → two data_valid pulses. With UART_RX_MAJORITY_VOTE_EN, a one-tick mid-bit glitch on rx does not corrupt data.
